engine_load_sched: RTL and testbench

//  Boot-time loader/sequencer for the BCP engine array. Once started, it walks every engine in order.
//  For each engine it reads the preprocessed clause-queue nodes from the node table and streams them
//  on node_in. It then sends that engine's dummy pointer and pulses change_eng to move to the next engine.

---
 rtl/engine_load_sched.sv | 146 ++++++++++++++
 tb/tb_engine_load_sched.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/engine_load_sched.sv
// Boot-time loader for the BCP engine array: streams each engine's clause-queue nodes and dummy
// pointer, steps the array between engines, then releases halt until a conflict or abort.
module engine_load_sched #(
  parameter int NUM_ENGINE    = 4,
  parameter int NODES_PER_ENG = 16,
  parameter int NODE_W        = 32,
  parameter int DUMMY_W       = 16,
  parameter int ADDR_W        = $clog2(NUM_ENGINE * NODES_PER_ENG)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          abort,
  input  logic                          conflict,
  output logic                          node_rd_en,
  output logic [ADDR_W-1:0]             node_rd_addr,
  input  logic [NODE_W-1:0]             node_rd_data,
  output logic                          dmy_rd_en,
  output logic [$clog2(NUM_ENGINE)-1:0] dmy_rd_addr,
  input  logic [DUMMY_W-1:0]            dmy_rd_data,
  output logic [NODE_W-1:0]             node_in,
  output logic                          node_in_valid,
  input  logic                          node_in_ready,
  output logic [DUMMY_W-1:0]            dummy_ptr,
  output logic                          dummy_ptr_valid,
  output logic                          change_eng,
  output logic                          halt,
  output logic [$clog2(NUM_ENGINE)-1:0] eng_idx,
  output logic                          busy
);

  localparam int ENG_W  = $clog2(NUM_ENGINE);
  localparam int NODE_CW = (NODES_PER_ENG > 1) ? $clog2(NODES_PER_ENG) : 1;
  localparam logic [ENG_W-1:0]   ENG_LAST  = ENG_W'(NUM_ENGINE - 1);
  localparam logic [NODE_CW-1:0] NODE_LAST = NODE_CW'(NODES_PER_ENG - 1);
  localparam logic [ADDR_W-1:0]  NODES_A   = ADDR_W'(NODES_PER_ENG);

  typedef enum logic [2:0] {
    IDLE,
    NRD,
    NSEND,
    DRD,
    DSEND,
    SWITCH,
    RUN
  } state_t;

  state_t               state;
  state_t               state_n;
  logic [ENG_W-1:0]     eng;
  logic [ENG_W-1:0]     eng_n;
  logic [NODE_CW-1:0]   node;
  logic [NODE_CW-1:0]   node_n;
  logic [NODE_W-1:0]    node_q;
  logic                 node_fresh;
  logic [DUMMY_W-1:0]   dummy_q;
  logic                 halt_q;
  logic                 loading;

  assign loading = (state != IDLE) && (state != RUN);

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state      <= IDLE;
      eng        <= '0;
      node       <= '0;
      node_q     <= '0;
      node_fresh <= 1'b0;
      dummy_q    <= '0;
      halt_q     <= 1'b1;
    end else begin
      state      <= state_n;
      eng        <= eng_n;
      node       <= node_n;
      // The table's own read register holds the word during the first NSEND cycle;
      // node_q takes over from then on so the word stays put while the array stalls.
      node_fresh <= (state == NRD) && !abort;
      if (node_fresh) begin
        node_q <= node_rd_data;
      end
      if (state == DSEND) begin
        dummy_q <= dmy_rd_data;
      end
      halt_q <= !((state == RUN) && !conflict && !abort);
    end
  end

  always_comb begin
    state_n = state;
    eng_n   = eng;
    node_n  = node;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = NRD;
          eng_n   = '0;
          node_n  = '0;
        end
      end
      NRD:   state_n = NSEND;
      NSEND: begin
        if (node_in_ready) begin
          if (node == NODE_LAST) begin
            node_n  = '0;
            state_n = DRD;
          end else begin
            node_n  = node + 1'b1;
            state_n = NRD;
          end
        end
      end
      DRD:   state_n = DSEND;
      DSEND: state_n = (eng == ENG_LAST) ? RUN : SWITCH;
      SWITCH: begin
        state_n = NRD;
        if (eng != ENG_LAST) begin
          eng_n = eng + 1'b1;
        end
      end
      RUN: begin
        if (conflict || abort) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    // Abort wins over any handshake completing in the same cycle.
    if (abort && loading) begin
      state_n = IDLE;
    end
  end

  assign node_rd_en      = (state == NRD);
  assign node_rd_addr    = ADDR_W'(eng) * NODES_A + ADDR_W'(node);
  assign dmy_rd_en       = (state == DRD);
  assign dmy_rd_addr     = eng;
  assign node_in_valid   = (state == NSEND);
  assign node_in         = node_fresh ? node_rd_data : node_q;
  assign dummy_ptr_valid = (state == DSEND);
  assign dummy_ptr       = dummy_ptr_valid ? dmy_rd_data : dummy_q;
  assign change_eng      = (state == SWITCH);
  assign halt            = halt_q;
  assign eng_idx         = eng;
  assign busy            = loading;

endmodule

// File: tb/tb_engine_load_sched.sv
// Directed bench for engine_load_sched with two engines of three nodes each.
module tb_engine_load_sched;

  localparam int NE  = 2;
  localparam int NPE = 3;
  localparam int AW  = $clog2(NE * NPE);
  localparam int EW  = $clog2(NE);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic          conflict;
  logic          node_rd_en;
  logic [AW-1:0] node_rd_addr;
  logic [31:0]   node_rd_data = '0;
  logic          dmy_rd_en;
  logic [EW-1:0] dmy_rd_addr;
  logic [15:0]   dmy_rd_data = '0;
  logic [31:0]   node_in;
  logic          node_in_valid;
  logic          node_in_ready;
  logic [15:0]   dummy_ptr;
  logic          dummy_ptr_valid;
  logic          change_eng;
  logic          halt;
  logic [EW-1:0] eng_idx;
  logic          busy;

  int passes = 0;
  int total  = 0;
  int cyc    = 0;
  int start_cyc = 0;
  int halt_fall = 0;
  logic halt_prev = 1'b1;
  int chg_cnt = 0;
  int addr_log[$];
  logic [15:0] dmy_log[$];
  logic [31:0] acc_log[$];

  engine_load_sched #(
    .NUM_ENGINE(NE), .NODES_PER_ENG(NPE), .NODE_W(32), .DUMMY_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .conflict(conflict),
    .node_rd_en(node_rd_en), .node_rd_addr(node_rd_addr), .node_rd_data(node_rd_data),
    .dmy_rd_en(dmy_rd_en), .dmy_rd_addr(dmy_rd_addr), .dmy_rd_data(dmy_rd_data),
    .node_in(node_in), .node_in_valid(node_in_valid), .node_in_ready(node_in_ready),
    .dummy_ptr(dummy_ptr), .dummy_ptr_valid(dummy_ptr_valid), .change_eng(change_eng),
    .halt(halt), .eng_idx(eng_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Node word i is A000_0000+i, dummy entry e is D000+e, both with one cycle of read latency.
  always @(posedge clk) begin
    if (node_rd_en) node_rd_data <= 32'hA000_0000 + 32'(node_rd_addr);
    if (dmy_rd_en) dmy_rd_data <= 16'hD000 + 16'(dmy_rd_addr);
  end

  always begin
    @(negedge clk);
    #2;
    if (rst_n) begin
      addr_log.delete();
      dmy_log.delete();
      acc_log.delete();
      chg_cnt   = 0;
      halt_fall = 0;
    end else begin
      if (node_rd_en) addr_log.push_back(int'(node_rd_addr));
      if (dummy_ptr_valid) dmy_log.push_back(dummy_ptr);
      if (node_in_valid && node_in_ready) acc_log.push_back(node_in);
      if (change_eng) chg_cnt++;
      if (halt_prev && !halt) halt_fall = cyc;
    end
    halt_prev = halt;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passes = passes + 1;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic applyStimulus(input logic s, input logic a, input logic c, input logic r,
                               input logic rs);
    #1;
    start         = s;
    abort         = a;
    conflict      = c;
    node_in_ready = r;
    rst_n         = rs;
  endtask

  task automatic resetDut();
    @(negedge clk); applyStimulus(0, 0, 0, 1, 1);
    @(negedge clk); applyStimulus(0, 0, 0, 1, 0);
  endtask

  task automatic startLoad(input logic hold);
    @(negedge clk); applyStimulus(1, 0, 0, 1, 0);
    start_cyc = cyc + 1;
    @(negedge clk); applyStimulus(hold, 0, 0, 1, 0);
  endtask

  task automatic waitRun(input int budget);
    int n = 0;
    while (halt !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("run_reached", 32'(halt), 32'd0);
  endtask

  initial begin
    int base;
    int bchg;
    rst_n = 1'b1; start = 1'b0; abort = 1'b0; conflict = 1'b0; node_in_ready = 1'b1;

    // Reset values
    @(negedge clk);
    checkOutput("rst_halt", 32'(halt), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_valid", 32'(node_in_valid), 32'd0);
    checkOutput("rst_node_in", node_in, 32'd0);
    checkOutput("rst_dummy_ptr", 32'(dummy_ptr), 32'd0);
    checkOutput("rst_dummy_valid", 32'(dummy_ptr_valid), 32'd0);
    checkOutput("rst_eng_idx", 32'(eng_idx), 32'd0);
    checkOutput("rst_change_eng", 32'(change_eng), 32'd0);
    @(negedge clk); applyStimulus(0, 0, 0, 1, 0);

    // 1: full load with ready tied high
    startLoad(0);
    checkOutput("t1_first_rd", 32'(node_rd_en), 32'd1);
    waitRun(60);
    @(negedge clk);
    checkOutput("t1_halt_delay", 32'(halt_fall - start_cyc), 32'd18);
    checkOutput("t1_addr_count", 32'(addr_log.size()), 32'd6);
    if (addr_log.size() == 6)
      for (int i = 0; i < 6; i++) checkOutput($sformatf("t1_addr%0d", i), 32'(addr_log[i]), 32'(i));
    checkOutput("t1_node_count", 32'(acc_log.size()), 32'd6);
    if (acc_log.size() == 6)
      for (int i = 0; i < 6; i++)
        checkOutput($sformatf("t1_node%0d", i), acc_log[i], 32'hA000_0000 + 32'(i));
    checkOutput("t1_dummy_count", 32'(dmy_log.size()), 32'd2);
    if (dmy_log.size() == 2) begin
      checkOutput("t1_dummy0", 32'(dmy_log[0]), 32'h0000_D000);
      checkOutput("t1_dummy1", 32'(dmy_log[1]), 32'h0000_D001);
    end
    checkOutput("t1_change_eng", 32'(chg_cnt), 32'd1);
    checkOutput("t1_busy", 32'(busy), 32'd0);
    checkOutput("t1_eng_idx", 32'(eng_idx), 32'd1);
    checkOutput("t1_dummy_hold", 32'(dummy_ptr), 32'h0000_D001);

    // 2: five stalled cycles on node 1
    resetDut();
    startLoad(0);
    repeat (3) @(negedge clk);
    checkOutput("t2_n1_valid", 32'(node_in_valid), 32'd1);
    checkOutput("t2_n1_data", node_in, 32'hA000_0001);
    applyStimulus(0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput($sformatf("t2_stall_valid%0d", i), 32'(node_in_valid), 32'd1);
      checkOutput($sformatf("t2_stall_data%0d", i), node_in, 32'hA000_0001);
    end
    applyStimulus(0, 0, 0, 1, 0);
    waitRun(60);
    @(negedge clk);
    checkOutput("t2_halt_delay", 32'(halt_fall - start_cyc), 32'd23);
    checkOutput("t2_addr_count", 32'(addr_log.size()), 32'd6);
    if (addr_log.size() == 6)
      for (int i = 0; i < 6; i++) checkOutput($sformatf("t2_addr%0d", i), 32'(addr_log[i]), 32'(i));
    checkOutput("t2_node_count", 32'(acc_log.size()), 32'd6);

    // 3: conflict in RUN re-halts; reload with start held high (6: held start ignored)
    @(negedge clk); applyStimulus(0, 0, 1, 1, 0);
    @(negedge clk);
    checkOutput("t3_halt_next", 32'(halt), 32'd1);
    checkOutput("t3_busy", 32'(busy), 32'd0);
    applyStimulus(0, 0, 0, 1, 0);
    repeat (2) @(negedge clk);
    checkOutput("t3_idle_halt", 32'(halt), 32'd1);
    checkOutput("t3_idle_rd", 32'(node_rd_en), 32'd0);
    base = addr_log.size();
    bchg = chg_cnt;
    startLoad(1);
    checkOutput("t3_reload_rd", 32'(node_rd_en), 32'd1);
    checkOutput("t3_reload_addr", 32'(node_rd_addr), 32'd0);
    checkOutput("t3_reload_eng", 32'(eng_idx), 32'd0);
    waitRun(60);
    @(negedge clk);
    checkOutput("t6_halt_delay", 32'(halt_fall - start_cyc), 32'd18);
    checkOutput("t6_addr_count", 32'(addr_log.size() - base), 32'd6);
    if (addr_log.size() >= base + 6) begin
      checkOutput("t6_addr_first", 32'(addr_log[base]), 32'd0);
      checkOutput("t6_addr_last", 32'(addr_log[base + 5]), 32'd5);
    end
    checkOutput("t6_change_eng", 32'(chg_cnt - bchg), 32'd1);
    repeat (3) @(negedge clk);
    checkOutput("t6_run_halt", 32'(halt), 32'd0);
    checkOutput("t6_run_busy", 32'(busy), 32'd0);
    checkOutput("t6_run_no_rd", 32'(addr_log.size() - base), 32'd6);
    applyStimulus(0, 0, 0, 1, 0);

    // 4: abort on node 4, without and with a coincident ready
    for (int v = 0; v < 2; v++) begin
      resetDut();
      startLoad(0);
      repeat (12) @(negedge clk);
      checkOutput($sformatf("t4_%0d_n4_valid", v), 32'(node_in_valid), 32'd1);
      checkOutput($sformatf("t4_%0d_n4_data", v), node_in, 32'hA000_0004);
      applyStimulus(0, 1, 0, (v == 1), 0);
      @(negedge clk);
      checkOutput($sformatf("t4_%0d_valid", v), 32'(node_in_valid), 32'd0);
      checkOutput($sformatf("t4_%0d_busy", v), 32'(busy), 32'd0);
      applyStimulus(0, 0, 0, 1, 0);
      repeat (10) @(negedge clk);
      checkOutput($sformatf("t4_%0d_halt", v), 32'(halt), 32'd1);
      checkOutput($sformatf("t4_%0d_dummies", v), 32'(dmy_log.size()), 32'd1);
      checkOutput($sformatf("t4_%0d_reads", v), 32'(addr_log.size()), 32'd5);
    end

    // 5: reset during DSEND of engine 0
    resetDut();
    startLoad(0);
    repeat (7) @(negedge clk);
    checkOutput("t5_dsend_valid", 32'(dummy_ptr_valid), 32'd1);
    checkOutput("t5_dsend_ptr", 32'(dummy_ptr), 32'h0000_D000);
    applyStimulus(0, 0, 0, 1, 1);
    @(negedge clk);
    checkOutput("t5_dummy_valid", 32'(dummy_ptr_valid), 32'd0);
    checkOutput("t5_dummy_ptr", 32'(dummy_ptr), 32'd0);
    checkOutput("t5_change_eng", 32'(change_eng), 32'd0);
    checkOutput("t5_node_in", node_in, 32'd0);
    checkOutput("t5_valid", 32'(node_in_valid), 32'd0);
    checkOutput("t5_halt", 32'(halt), 32'd1);
    checkOutput("t5_busy", 32'(busy), 32'd0);
    checkOutput("t5_eng_idx", 32'(eng_idx), 32'd0);
    checkOutput("t5_rd", 32'(node_rd_en | dmy_rd_en), 32'd0);
    applyStimulus(0, 0, 0, 1, 0);

    @(negedge clk);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
